// File: rtl/wht_sched.sv
// rtl/wht_sched.sv - two-requester scheduler that streams 4x4 blocks column-wise to a transform engine
//
// Accepts one 4x4 pixel block at a time from two round-robin requesters, issues
// its four columns to the engine on consecutive cycles, then collects four
// result beats and forwards them with the requester tag.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/reqN_blk        requester N offers a block (pixel (r,c) at slice 4r+c)
//   reqN_ready                 combinational grant, only while idle
//   eng_col/eng_ivalid         registered column to engine (lane r = pixel (r,c))
//   eng_res/eng_ovalid         engine result beat (4 coefficients)
//   res_data/res_valid         registered result beat
//   res_last/res_tag           4th beat of the block / requester index
//   busy                       a block is in flight
//   err_timeout/err_proto      single-cycle error pulses
module wht_sched #(
  parameter int WIDTH0  = 8,
  parameter int WIDTH2  = 13,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [16*WIDTH0-1:0] req0_blk,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [16*WIDTH0-1:0] req1_blk,
  output logic                 req1_ready,
  output logic [4*WIDTH0-1:0]  eng_col,
  output logic                 eng_ivalid,
  input  logic [4*WIDTH2-1:0]  eng_res,
  input  logic                 eng_ovalid,
  output logic [4*WIDTH2-1:0]  res_data,
  output logic                 res_valid,
  output logic                 res_last,
  output logic                 res_tag,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_proto
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_COLLECT = 2'd3;

  localparam int            TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]           state;
  logic [16*WIDTH0-1:0] blk_q;
  logic                 tag_q;
  logic                 last_grant;
  logic [1:0]           col_cnt;
  logic [1:0]           beat_cnt;
  logic [TW-1:0]        to_cnt;
  logic                 grant0;
  logic                 grant1;
  logic [16*WIDTH0-1:0] sel_blk;

  // Column c of a block: lane r carries pixel (r,c).
  function automatic logic [4*WIDTH0-1:0] col_of(input logic [16*WIDTH0-1:0] blk,
                                                 input logic [1:0]           c);
    logic [4*WIDTH0-1:0] col;
    col = '0;
    for (int r = 0; r < 4; r++) begin
      col[r*WIDTH0 +: WIDTH0] = blk[(4*r + int'(c))*WIDTH0 +: WIDTH0];
    end
    return col;
  endfunction

  // Round-robin: on contention favour the requester not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_IDLE) begin
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign sel_blk    = grant1 ? req1_blk : req0_blk;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      blk_q       <= '0;
      tag_q       <= 1'b0;
      last_grant  <= 1'b1;
      col_cnt     <= 2'd0;
      beat_cnt    <= 2'd0;
      to_cnt      <= '0;
      eng_col     <= '0;
      eng_ivalid  <= 1'b0;
      res_data    <= '0;
      res_valid   <= 1'b0;
      res_last    <= 1'b0;
      res_tag     <= 1'b0;
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
    end else begin
      res_valid   <= 1'b0;
      res_last    <= 1'b0;
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (eng_ovalid) err_proto <= 1'b1;
          if (grant0 || grant1) begin
            blk_q      <= sel_blk;
            tag_q      <= grant1;
            last_grant <= grant1;
            col_cnt    <= 2'd0;
            beat_cnt   <= 2'd0;
            to_cnt     <= '0;
            // Column 0 is loaded at the grant edge so eng_ivalid lines up
            // with the four ISSUE cycles exactly.
            eng_col    <= col_of(sel_blk, 2'd0);
            eng_ivalid <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (eng_ovalid) err_proto <= 1'b1;
          if (col_cnt == 2'd3) begin
            eng_ivalid <= 1'b0;
            to_cnt     <= '0;
            state      <= S_WAIT;
          end else begin
            col_cnt <= col_cnt + 2'd1;
            eng_col <= col_of(blk_q, col_cnt + 2'd1);
          end
        end
        S_WAIT: begin
          if (eng_ovalid) begin
            res_valid <= 1'b1;
            res_data  <= eng_res;
            res_tag   <= tag_q;
            beat_cnt  <= 2'd1;
            state     <= S_COLLECT;
          end else if (to_cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: begin
          if (eng_ovalid) begin
            res_valid <= 1'b1;
            res_data  <= eng_res;
            res_tag   <= tag_q;
            beat_cnt  <= beat_cnt + 2'd1;
            if (beat_cnt == 2'd3) begin
              res_last <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
